// File: rtl/shield_write_seq_pkg.sv
// shield_write_seq_pkg: shared widths and FSM states for the shield write chunk sequencer
package shield_write_seq_pkg;
    localparam int LINE_W = 512;
    localparam int TAG_W  = 128;
    localparam int CTR_W  = 32;
    localparam int IV_W   = 64;
    localparam int ADDR_W = 32;
    typedef enum logic [2:0] {IDLE, ENC, DRAIN_ENC, AUTH, TAG, EMIT} seq_state_e;
endpackage

// File: rtl/shield_cipher_fifo.sv
// shield_cipher_fifo: ciphertext line buffer between the encryptor (no backpressure) and the memory write port
module shield_cipher_fifo
    import shield_write_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LINE_W-1:0] wr_data,
    input  logic              wr_en,
    output logic [LINE_W-1:0] rd_data,
    output logic              rd_val,
    input  logic              rd_rdy,
    output logic [CW-1:0]     count
);
    logic [LINE_W-1:0] mem_q [DEPTH];
    logic [LINE_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push, pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign rd_val  = count_q != '0;
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Next pointers, occupancy and storage; a push at full only lands alongside a pop
    always_comb begin
        pop      = rd_val && rd_rdy;
        push     = wr_en && (count_q != CW'(DEPTH) || pop);
        mem_d    = mem_q;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (push) mem_d[wr_ptr_q] = wr_data;
    end

    // Register storage and pointers; reset empties the buffer and clears every line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/shield_write_chunk_sequencer.sv
// shield_write_chunk_sequencer: feeds plaintext chunks to the encryptor, forwards ciphertext, then emits one tag per chunk
module shield_write_chunk_sequencer
    import shield_write_seq_pkg::*;
#(
    parameter int CHUNK_BEATS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IV_W-1:0]   cfg_iv,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [CTR_W-1:0]  in_counter,
    input  logic [LINE_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_val,
    output logic              in_rdy,
    output logic [LINE_W-1:0] enc_req_data,
    output logic [CTR_W-1:0]  enc_req_counter,
    output logic [IV_W-1:0]   enc_req_iv,
    output logic              enc_req_val,
    input  logic              enc_req_rdy,
    input  logic [LINE_W-1:0] enc_resp_data,
    input  logic              enc_resp_val,
    output logic              auth_start,
    output logic [CTR_W-1:0]  auth_req_counter,
    output logic [ADDR_W-1:0] auth_req_addr,
    input  logic [TAG_W-1:0]  auth_resp_tag,
    input  logic              auth_resp_val,
    output logic              auth_resp_rdy,
    output logic [LINE_W-1:0] out_data,
    output logic              out_val,
    input  logic              out_rdy,
    output logic [TAG_W-1:0]  out_tag,
    output logic [ADDR_W-1:0] out_tag_addr,
    output logic              out_tag_val,
    input  logic              out_tag_rdy
);
    localparam int CW = $clog2(CHUNK_BEATS + 1);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, tag_addr_q, tag_addr_d;
    logic [CTR_W-1:0]  ctr_q, ctr_d;
    logic [IV_W-1:0]   iv_q, iv_d;
    logic [LINE_W-1:0] req_data_q, req_data_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [CW-1:0]     outstanding_q, outstanding_d, beat_cnt_q, beat_cnt_d, fifo_count;
    logic              req_hold_q, req_hold_d, auth_start_q, auth_start_d, tag_val_q, tag_val_d;
    logic              in_hs, req_hs, in_space;

    // Lines in flight (held, at the encryptor, or buffered) never exceed the buffer depth
    assign in_space = (32'(outstanding_q) + 32'(fifo_count) + 32'(req_hold_q)) < 32'(CHUNK_BEATS);
    assign in_rdy   = (state_q == ENC) && (!req_hold_q || enc_req_rdy) && in_space;
    assign in_hs    = in_val && in_rdy;
    assign req_hs   = req_hold_q && enc_req_rdy;

    assign enc_req_val      = req_hold_q;
    assign enc_req_data     = req_data_q;
    assign enc_req_counter  = ctr_q;
    assign enc_req_iv       = iv_q;
    assign auth_start       = auth_start_q;
    assign auth_req_counter = ctr_q;
    assign auth_req_addr    = addr_q;
    assign auth_resp_rdy    = (state_q == TAG) && (fifo_count == '0);
    assign out_tag          = tag_q;
    assign out_tag_addr     = tag_addr_q;
    assign out_tag_val      = tag_val_q;

    shield_cipher_fifo #(.DEPTH(CHUNK_BEATS)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_data (enc_resp_data),
        .wr_en   (enc_resp_val),
        .rd_data (out_data),
        .rd_val  (out_val),
        .rd_rdy  (out_rdy),
        .count   (fifo_count)
    );

    // Chunk FSM next state: latch chunk context, issue lines, wait for ciphertext, then authenticate and emit the tag
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        ctr_d         = ctr_q;
        iv_d          = iv_q;
        req_data_d    = in_hs ? in_data : req_data_q;
        req_hold_d    = in_hs || (req_hold_q && !enc_req_rdy);
        beat_cnt_d    = beat_cnt_q + CW'(in_hs);
        outstanding_d = outstanding_q + CW'(req_hs) - CW'(enc_resp_val);
        auth_start_d  = auth_start_q;
        tag_d         = tag_q;
        tag_addr_d    = tag_addr_q;
        tag_val_d     = tag_val_q;
        case (state_q)
            IDLE: if (in_val) begin
                addr_d     = in_addr;
                ctr_d      = in_counter;
                iv_d       = cfg_iv;
                beat_cnt_d = '0;
                state_d    = ENC;
            end
            ENC: if (in_hs && (in_last || beat_cnt_q == CW'(CHUNK_BEATS - 1))) state_d = DRAIN_ENC;
            DRAIN_ENC: if (!req_hold_q && outstanding_d == '0) begin
                auth_start_d = 1'b1;
                state_d      = AUTH;
            end
            AUTH: if (auth_resp_val) begin
                auth_start_d = 1'b0;
                state_d      = TAG;
            end
            TAG: if (auth_resp_val && auth_resp_rdy) begin
                tag_d      = auth_resp_tag;
                tag_addr_d = addr_q;
                tag_val_d  = 1'b1;
                state_d    = EMIT;
            end
            EMIT: if (out_tag_rdy) begin
                tag_val_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // All sequencer state; reset discards any partial chunk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            ctr_q         <= '0;
            iv_q          <= '0;
            req_data_q    <= '0;
            req_hold_q    <= 1'b0;
            beat_cnt_q    <= '0;
            outstanding_q <= '0;
            auth_start_q  <= 1'b0;
            tag_q         <= '0;
            tag_addr_q    <= '0;
            tag_val_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            ctr_q         <= ctr_d;
            iv_q          <= iv_d;
            req_data_q    <= req_data_d;
            req_hold_q    <= req_hold_d;
            beat_cnt_q    <= beat_cnt_d;
            outstanding_q <= outstanding_d;
            auth_start_q  <= auth_start_d;
            tag_q         <= tag_d;
            tag_addr_q    <= tag_addr_d;
            tag_val_q     <= tag_val_d;
        end
    end
endmodule

// File: tb/tb_shield_write_chunk_sequencer.sv
// tb_shield_write_chunk_sequencer: directed bench with behavioural encryptor and authenticator models
module tb_shield_write_chunk_sequencer;
    localparam int CB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [63:0] cfg_iv;
    logic [31:0] in_addr, in_counter;
    logic [511:0] in_data;
    logic in_last, in_val, in_rdy;
    logic [511:0] enc_req_data;
    logic [31:0] enc_req_counter;
    logic [63:0] enc_req_iv;
    logic enc_req_val, enc_req_rdy;
    logic [511:0] enc_resp_data;
    logic enc_resp_val;
    logic auth_start;
    logic [31:0] auth_req_counter, auth_req_addr;
    logic [127:0] auth_resp_tag;
    logic auth_resp_val, auth_resp_rdy;
    logic [511:0] out_data;
    logic out_val, out_rdy;
    logic [127:0] out_tag;
    logic [31:0] out_tag_addr;
    logic out_tag_val, out_tag_rdy;

    always #5 clk = ~clk;

    shield_write_chunk_sequencer #(.CHUNK_BEATS(CB)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_iv(cfg_iv),
        .in_addr(in_addr), .in_counter(in_counter), .in_data(in_data), .in_last(in_last),
        .in_val(in_val), .in_rdy(in_rdy),
        .enc_req_data(enc_req_data), .enc_req_counter(enc_req_counter), .enc_req_iv(enc_req_iv),
        .enc_req_val(enc_req_val), .enc_req_rdy(enc_req_rdy),
        .enc_resp_data(enc_resp_data), .enc_resp_val(enc_resp_val),
        .auth_start(auth_start), .auth_req_counter(auth_req_counter), .auth_req_addr(auth_req_addr),
        .auth_resp_tag(auth_resp_tag), .auth_resp_val(auth_resp_val), .auth_resp_rdy(auth_resp_rdy),
        .out_data(out_data), .out_val(out_val), .out_rdy(out_rdy),
        .out_tag(out_tag), .out_tag_addr(out_tag_addr), .out_tag_val(out_tag_val), .out_tag_rdy(out_tag_rdy)
    );

    int tests = 0, fails = 0, cyc = 0;
    int fcount, ovf, tag_unstable, auth_start_cycles, auth_overlap, auth_rdy_cycles, auth_delay, auth_cnt;
    logic auth_busy, auth_hs, prev_tag_hold;
    logic [127:0] prev_tag;
    logic [31:0] auth_seen_addr;
    logic [511:0] got_data[$];
    logic [127:0] got_tag[$];
    logic [31:0] got_tag_addr[$];
    int got_tag_pos[$];
    logic [31:0] req_ctr[$];
    logic [63:0] req_iv[$];
    int req_cyc[$];
    logic [511:0] enc_q_data[$];
    int enc_q_due[$];

    function automatic logic [511:0] enc_model(input logic [511:0] d, input logic [31:0] c, input logic [63:0] iv);
        return d ^ {16{c ^ iv[31:0] ^ {iv[47:32], iv[63:48]} ^ 32'h9d2c4daa}};
    endfunction

    function automatic logic [127:0] tag_model(input logic [31:0] a, input logic [31:0] c);
        return {a ^ 32'h103d4ddc, c ^ 32'h45299f22, ~a, ~c};
    endfunction

    function automatic logic [511:0] line_pat(input int i);
        return {16{32'(i + 1) * 32'h01234567}};
    endfunction

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        got_data.delete(); got_tag.delete(); got_tag_addr.delete(); got_tag_pos.delete();
        req_ctr.delete(); req_iv.delete(); req_cyc.delete();
        fcount = 0; tag_unstable = 0; prev_tag_hold = 0;
        auth_start_cycles = 0; auth_overlap = 0; auth_rdy_cycles = 0; auth_hs = 0;
    endtask

    task automatic send_beat(input logic [31:0] a, input logic [31:0] c, input logic [511:0] d, input logic last);
        int n = 0;
        in_val = 1; in_addr = a; in_counter = c; in_data = d; in_last = last;
        do begin @(negedge clk); n++; end while (!in_rdy && n < 200);
        if (!in_rdy) check("in_rdy_timeout", in_rdy, 1);
        @(posedge clk); #1;
        in_val = 0; in_last = 0;
    endtask

    task automatic wait_tags(input int n);
        int k = 0;
        while (got_tag.size() < n && k < 500) begin @(negedge clk); k++; end
        check("tag_count", got_tag.size(), n);
        repeat (3) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    // Observers: handshakes seen here complete at the following posedge
    always @(negedge clk) begin
        if (rst_n) begin
            if (enc_req_val && enc_req_rdy) begin
                req_ctr.push_back(enc_req_counter);
                req_iv.push_back(enc_req_iv);
                req_cyc.push_back(cyc);
                enc_q_data.push_back(enc_model(enc_req_data, enc_req_counter, enc_req_iv));
                enc_q_due.push_back(cyc + 2);
            end
            if (out_val && out_rdy) got_data.push_back(out_data);
            if (out_tag_val && out_tag_rdy) begin
                got_tag.push_back(out_tag);
                got_tag_addr.push_back(out_tag_addr);
                got_tag_pos.push_back(got_data.size());
            end
            fcount += int'(enc_resp_val) - int'(out_val && out_rdy);
            if (fcount > CB) ovf++;
            if (prev_tag_hold && (!out_tag_val || out_tag !== prev_tag)) tag_unstable++;
            prev_tag_hold = out_tag_val && !out_tag_rdy;
            prev_tag = out_tag;
            if (auth_start) auth_start_cycles++;
            if (auth_start && auth_resp_val) auth_overlap++;
            if (auth_resp_rdy) auth_rdy_cycles++;
            auth_hs = auth_resp_val && auth_resp_rdy;
        end
    end

    // Encryptor: fixed two-cycle latency, one single-cycle response per request
    initial forever begin
        @(posedge clk); #1;
        enc_resp_val = 0;
        if (!rst_n) begin
            enc_q_data.delete();
            enc_q_due.delete();
        end else if (enc_q_due.size() > 0 && enc_q_due[0] <= cyc) begin
            enc_resp_val = 1;
            enc_resp_data = enc_q_data.pop_front();
            void'(enc_q_due.pop_front());
        end
    end

    // Authenticator: answers auth_delay cycles after auth_start and holds the tag until accepted
    initial forever begin
        @(posedge clk); #1;
        if (!rst_n) begin
            auth_resp_val = 0;
            auth_busy = 0;
        end else begin
            if (auth_hs) begin
                auth_resp_val = 0;
                auth_busy = 0;
            end else if (!auth_busy && auth_start) begin
                auth_busy = 1;
                auth_cnt = auth_delay;
                auth_seen_addr = auth_req_addr;
            end
            if (auth_busy && !auth_resp_val) begin
                if (auth_cnt == 0) begin
                    auth_resp_val = 1;
                    auth_resp_tag = tag_model(auth_req_addr, auth_req_counter);
                end else auth_cnt--;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, c;
        int bad, k;
        cfg_iv = 0; in_addr = 0; in_counter = 0; in_data = 0; in_last = 0; in_val = 0;
        enc_req_rdy = 1; enc_resp_val = 0; enc_resp_data = 0;
        auth_resp_val = 0; auth_resp_tag = 0; auth_busy = 0; auth_delay = 2; auth_cnt = 0;
        out_rdy = 1; out_tag_rdy = 1; ovf = 0; auth_seen_addr = 0; prev_tag = 0;
        clear_logs();
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_rdy", in_rdy, 0);
        check("rst_enc_req_val", enc_req_val, 0);
        check("rst_out_val", out_val, 0);
        check("rst_out_tag_val", out_tag_val, 0);
        check("rst_auth_start", auth_start, 0);
        check("rst_auth_resp_rdy", auth_resp_rdy, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_enc_req_counter", enc_req_counter, 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;

        // single-line chunk
        clear_logs();
        send_beat(32'h0, 32'h0, 512'h0, 1);
        wait_tags(1);
        check("t1_req_count", req_ctr.size(), 1);
        check("t1_req_ctr", req_ctr[0], 0);
        check("t1_data_count", got_data.size(), 1);
        check("t1_data", got_data[0], enc_model(512'h0, 32'h0, 64'h0));
        check("t1_auth_addr", auth_seen_addr, 0);
        check("t1_tag", got_tag[0], tag_model(32'h0, 32'h0));
        check("t1_tag_pos", got_tag_pos[0], 1);

        // four-line chunk, no backpressure
        clear_logs();
        cfg_iv = 64'hdeadbeefdeadbeef;
        for (int i = 0; i < 4; i++)
            send_beat(i == 0 ? 32'habcdef01 : 32'hffffffff, i == 0 ? 32'h23456789 : 32'hffffffff, line_pat(i), i == 3);
        wait_tags(1);
        check("t2_req_count", req_ctr.size(), 4);
        check("t2_req_span", req_cyc[3] - req_cyc[0], 3);
        bad = 0;
        for (int i = 0; i < req_ctr.size(); i++)
            if (req_ctr[i] !== 32'h23456789 || req_iv[i] !== 64'hdeadbeefdeadbeef) bad++;
        check("t2_req_fields", bad, 0);
        check("t2_data_count", got_data.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_data%0d", i), got_data[i], enc_model(line_pat(i), 32'h23456789, 64'hdeadbeefdeadbeef));
        check("t2_tag_addr", got_tag_addr[0], 32'habcdef01);
        check("t2_tag", got_tag[0], tag_model(32'habcdef01, 32'h23456789));
        check("t2_tag_pos", got_tag_pos[0], 4);

        // forced close after CB beats, second chunk re-latched from beat 5
        clear_logs();
        for (int i = 0; i < 6; i++) begin
            a = i == 0 ? 32'h1000 : i == 4 ? 32'h2000 : 32'hffffffff;
            c = i == 0 ? 32'h11 : i == 4 ? 32'h22 : 32'hffffffff;
            send_beat(a, c, line_pat(i), i == 5);
        end
        wait_tags(2);
        check("t3_data_count", got_data.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("t3_data%0d", i), got_data[i], enc_model(line_pat(i), i < 4 ? 32'h11 : 32'h22, cfg_iv));
        check("t3_req_ctr_b", req_ctr[4], 32'h22);
        check("t3_tag_a", got_tag[0], tag_model(32'h1000, 32'h11));
        check("t3_tag_b", got_tag[1], tag_model(32'h2000, 32'h22));
        check("t3_tag_addr_b", got_tag_addr[1], 32'h2000);
        check("t3_pos_a", got_tag_pos[0], 4);
        check("t3_pos_b", got_tag_pos[1], 6);

        // memory stall with tag sink also stalled
        clear_logs();
        out_rdy = 0; out_tag_rdy = 0;
        for (int i = 0; i < 4; i++) send_beat(i == 0 ? 32'h4000 : 32'h0, i == 0 ? 32'h44 : 32'h0, line_pat(i + 8), i == 3);
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("t4_fifo_level", fcount, 4);
        check("t4_out_val", out_val, 1);
        check("t4_in_rdy", in_rdy, 0);
        check("t4_tag_held", out_tag_val, 0);
        @(posedge clk); #1;
        out_rdy = 1;
        k = 0;
        while (!out_tag_val && k < 100) begin @(negedge clk); k++; end
        check("t4_tag_val", out_tag_val, 1);
        repeat (5) @(negedge clk);
        check("t4_tag_still_val", out_tag_val, 1);
        check("t4_tag_stable", tag_unstable, 0);
        check("t4_data_count", got_data.size(), 4);
        @(posedge clk); #1;
        out_tag_rdy = 1;
        wait_tags(1);
        for (int i = 0; i < 4; i++)
            check($sformatf("t4_data%0d", i), got_data[i], enc_model(line_pat(i + 8), 32'h44, cfg_iv));
        check("t4_tag", got_tag[0], tag_model(32'h4000, 32'h44));
        check("t4_tag_pos", got_tag_pos[0], 4);

        // slow authenticator
        clear_logs();
        auth_delay = 10;
        send_beat(32'h5000, 32'h55, line_pat(20), 0);
        send_beat(32'h0, 32'h0, line_pat(21), 1);
        wait_tags(1);
        check("t5_auth_start_cycles", auth_start_cycles, 11);
        check("t5_auth_overlap", auth_overlap, 1);
        check("t5_auth_rdy_cycles", auth_rdy_cycles, 1);
        check("t5_tag", got_tag[0], tag_model(32'h5000, 32'h55));
        auth_delay = 2;

        // reset after two of four requests
        clear_logs();
        send_beat(32'h6000, 32'h66, line_pat(30), 0);
        send_beat(32'h0, 32'h0, line_pat(31), 0);
        @(posedge clk); #1;
        check("t6_reqs_before_reset", req_ctr.size(), 2);
        rst_n = 0;
        #1;
        check("t6_in_rdy", in_rdy, 0);
        check("t6_enc_req_val", enc_req_val, 0);
        check("t6_out_val", out_val, 0);
        check("t6_out_tag_val", out_tag_val, 0);
        check("t6_auth_start", auth_start, 0);
        check("t6_enc_req_counter", enc_req_counter, 0);
        check("t6_out_data", out_data, 0);
        check("t6_auth_req_addr", auth_req_addr, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        clear_logs();
        send_beat(32'h7000, 32'h77, line_pat(40), 0);
        send_beat(32'h0, 32'h0, line_pat(41), 1);
        wait_tags(1);
        check("t6_data_count", got_data.size(), 2);
        check("t6_data0", got_data[0], enc_model(line_pat(40), 32'h77, cfg_iv));
        check("t6_data1", got_data[1], enc_model(line_pat(41), 32'h77, cfg_iv));
        check("t6_tag", got_tag[0], tag_model(32'h7000, 32'h77));
        check("t6_tag_addr", got_tag_addr[0], 32'h7000);

        check("no_overflow", ovf, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
